// File: rtl/hella_arb_pkg.sv
// Shared constants and helpers for the N-way HellaCache arbiter.
// Exports M_CMD_W, TYP_W, XCPT_W and the clog2_min1 index-width function.
package hella_arb_pkg;

   localparam int M_CMD_W = 5;
   localparam int TYP_W   = 3;
   localparam int XCPT_W  = 4;

   // Index width for n requestors, never below one bit.
   function automatic int clog2_min1(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/hella_arb_pick.sv
// N-way request picker: one-hot grant plus winner index.
// Ports: valid (N) in; rr (IDX_W) in when HELLA_ARB_RR_EN; gnt (N), idx (IDX_W) out.
// Macro HELLA_ARB_RR_EN: search starts at rr, else lowest index wins.
module hella_arb_pick
   import hella_arb_pkg::*;
#(
   parameter int N     = 2,
   parameter int IDX_W = clog2_min1(N)
) (
`ifdef HELLA_ARB_RR_EN
   input  logic [IDX_W-1:0] rr,
`endif
   input  logic [N-1:0]     valid,
   output logic [N-1:0]     gnt,
   output logic [IDX_W-1:0] idx
);

   logic [IDX_W-1:0] base;
   logic             found;
   int               j;

`ifdef HELLA_ARB_RR_EN
   assign base = rr;
`else
   assign base = '0;
`endif

   // Scan N slots starting at base, wrapping once.
   always_comb begin
      gnt   = '0;
      idx   = '0;
      found = 1'b0;
      j     = 0;
      for (int k = 0; k < N; k++) begin
         j = int'(base) + k;
         if (j >= N) j = j - N;
         if (!found && valid[j]) begin
            found  = 1'b1;
            gnt[j] = 1'b1;
            idx    = IDX_W'(j);
         end
      end
   end

endmodule

// File: rtl/hella_cache_arbiter_n.sv
// N-requestor HellaCache arbiter: grants one request per cycle, appends the
// requestor index to the tag, tracks ownership through s1/s2 and routes
// s1_kill/s1_data, s2_nack and tagged responses to the right client.
// Ports: io_requestor_* (N packed clients), io_mem_* (single cache port),
// clk, reset (sync, active-high). Macro HELLA_ARB_RR_EN selects round-robin.
module hella_cache_arbiter_n
   import hella_arb_pkg::*;
#(
   parameter int N      = 2,
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int TAG_W  = 9,
   parameter int IDX_W  = clog2_min1(N)
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [N-1:0]           io_requestor_req_valid,
   output logic [N-1:0]           io_requestor_req_ready,
   input  logic [N*ADDR_W-1:0]    io_requestor_req_bits_addr,
   input  logic [N*TAG_W-1:0]     io_requestor_req_bits_tag,
   input  logic [N*M_CMD_W-1:0]   io_requestor_req_bits_cmd,
   input  logic [N*TYP_W-1:0]     io_requestor_req_bits_typ,
   input  logic [N-1:0]           io_requestor_req_bits_phys,
   input  logic [N*DATA_W-1:0]    io_requestor_req_bits_data,
   input  logic [N-1:0]           io_requestor_s1_kill,
   input  logic [N*DATA_W-1:0]    io_requestor_s1_data,
   output logic [N-1:0]           io_requestor_s2_nack,
   output logic [N-1:0]           io_requestor_resp_valid,
   output logic [TAG_W-1:0]       io_requestor_resp_bits_tag,
   output logic [DATA_W-1:0]      io_requestor_resp_bits_data,
   output logic                   io_requestor_resp_bits_has_data,
   output logic                   io_requestor_resp_bits_replay,
   output logic                   io_requestor_replay_next,
   output logic [XCPT_W-1:0]      io_requestor_xcpt,
   input  logic [N-1:0]           io_requestor_invalidate_lr,
   output logic                   io_requestor_ordered,
   output logic                   io_mem_req_valid,
   input  logic                   io_mem_req_ready,
   output logic [ADDR_W-1:0]      io_mem_req_bits_addr,
   output logic [TAG_W+IDX_W-1:0] io_mem_req_bits_tag,
   output logic [M_CMD_W-1:0]     io_mem_req_bits_cmd,
   output logic [TYP_W-1:0]       io_mem_req_bits_typ,
   output logic                   io_mem_req_bits_phys,
   output logic [DATA_W-1:0]      io_mem_req_bits_data,
   output logic                   io_mem_s1_kill,
   output logic [DATA_W-1:0]      io_mem_s1_data,
   input  logic                   io_mem_s2_nack,
   input  logic                   io_mem_resp_valid,
   input  logic [TAG_W+IDX_W-1:0] io_mem_resp_bits_tag,
   input  logic [DATA_W-1:0]      io_mem_resp_bits_data,
   input  logic                   io_mem_resp_bits_has_data,
   input  logic                   io_mem_resp_bits_replay,
   input  logic                   io_mem_replay_next,
   input  logic [XCPT_W-1:0]      io_mem_xcpt,
   input  logic                   io_mem_ordered,
   output logic                   io_mem_invalidate_lr
);

   logic [N-1:0]     gnt;
   logic [IDX_W-1:0] win;
   logic             fire;
   logic             s1_valid;
   logic             s2_valid;
   logic [IDX_W-1:0] s1_id;
   logic [IDX_W-1:0] s2_id;
   logic [IDX_W-1:0] resp_idx;

`ifdef HELLA_ARB_RR_EN
   logic [IDX_W-1:0] rr;
`endif

   hella_arb_pick #(
      .N     (N),
      .IDX_W (IDX_W)
   ) u_pick (
`ifdef HELLA_ARB_RR_EN
      .rr    (rr),
`endif
      .valid (io_requestor_req_valid),
      .gnt   (gnt),
      .idx   (win)
   );

   // Request path: winner's fields straight through, no buffering.
   assign io_mem_req_valid = |io_requestor_req_valid;
   assign fire = io_mem_req_valid & io_mem_req_ready;
   assign io_requestor_req_ready = gnt & {N{io_mem_req_ready}};

   assign io_mem_req_bits_addr =
      io_requestor_req_bits_addr[int'(win)*ADDR_W +: ADDR_W];
   assign io_mem_req_bits_tag = {
      io_requestor_req_bits_tag[int'(win)*TAG_W +: TAG_W], win};
   assign io_mem_req_bits_cmd =
      io_requestor_req_bits_cmd[int'(win)*M_CMD_W +: M_CMD_W];
   assign io_mem_req_bits_typ =
      io_requestor_req_bits_typ[int'(win)*TYP_W +: TYP_W];
   assign io_mem_req_bits_phys =
      io_requestor_req_bits_phys[int'(win)];
   assign io_mem_req_bits_data =
      io_requestor_req_bits_data[int'(win)*DATA_W +: DATA_W];

   // Ownership pipeline: who issued the request now in s1 and in s2.
   always_ff @(posedge clk) begin
      if (reset) begin
         s1_valid <= 1'b0;
         s2_valid <= 1'b0;
         s1_id    <= '0;
         s2_id    <= '0;
      end else begin
         s1_valid <= fire;
         s1_id    <= win;
         s2_valid <= s1_valid;
         s2_id    <= s1_id;
      end
   end

`ifdef HELLA_ARB_RR_EN
   // Next search starts just past the last winner.
   always_ff @(posedge clk) begin
      if (reset) begin
         rr <= '0;
      end else if (fire) begin
         if (int'(win) == N - 1) rr <= '0;
         else                    rr <= win + 1'b1;
      end
   end
`endif

   // Stage-1 sideband from the s1 owner only.
   assign io_mem_s1_kill =
      s1_valid & io_requestor_s1_kill[int'(s1_id)];
   assign io_mem_s1_data = s1_valid ?
      io_requestor_s1_data[int'(s1_id)*DATA_W +: DATA_W] : '0;

   // Nack and response steering; an index past N-1 matches nobody.
   assign resp_idx = io_mem_resp_bits_tag[IDX_W-1:0];

   for (genvar i = 0; i < N; i++) begin : g_route
      assign io_requestor_s2_nack[i] =
         io_mem_s2_nack & s2_valid & (s2_id == IDX_W'(i));
      assign io_requestor_resp_valid[i] =
         io_mem_resp_valid & (resp_idx == IDX_W'(i));
   end

   assign io_requestor_resp_bits_tag =
      io_mem_resp_bits_tag[TAG_W+IDX_W-1:IDX_W];
   assign io_requestor_resp_bits_data     = io_mem_resp_bits_data;
   assign io_requestor_resp_bits_has_data = io_mem_resp_bits_has_data;
   assign io_requestor_resp_bits_replay   = io_mem_resp_bits_replay;
   assign io_requestor_replay_next        = io_mem_replay_next;
   assign io_requestor_xcpt               = io_mem_xcpt;
   assign io_requestor_ordered            = io_mem_ordered;
   assign io_mem_invalidate_lr = |io_requestor_invalidate_lr;

endmodule

// File: tb/tb_hella_cache_arbiter_n.sv
// Directed bench for hella_cache_arbiter_n (N=2, plus N=3 round-robin
// instance when HELLA_ARB_RR_EN is defined).
module tb_hella_cache_arbiter_n;

   logic        clk = 1'b0;
   logic        reset;
   int          n_cmp = 0;
   int          n_bad = 0;

   logic [1:0]  rq_valid, rq_ready, rq_phys, rq_kill;
   logic [63:0] rq_addr, rq_data, rq_s1_data;
   logic [17:0] rq_tag;
   logic [9:0]  rq_cmd;
   logic [5:0]  rq_typ;
   logic [1:0]  rq_nack, rs_valid, inv_lr;
   logic [8:0]  rs_tag;
   logic [31:0] rs_data;
   logic        rs_has, rs_replay, rp_next, ordered;
   logic [3:0]  xcpt;
   logic        m_valid, m_ready, m_phys, m_kill, m_nack;
   logic [31:0] m_addr, m_data, m_s1_data;
   logic [9:0]  m_tag, m_rtag;
   logic [4:0]  m_cmd;
   logic [2:0]  m_typ;
   logic        m_rvalid, m_has, m_replay, m_rp_next;
   logic        m_ordered, m_inv_lr;
   logic [31:0] m_rdata;
   logic [3:0]  m_xcpt;

   always #5 clk = ~clk;

   hella_cache_arbiter_n #(
      .N(2), .ADDR_W(32), .DATA_W(32), .TAG_W(9)
   ) dut (
      .clk(clk), .reset(reset),
      .io_requestor_req_valid(rq_valid),
      .io_requestor_req_ready(rq_ready),
      .io_requestor_req_bits_addr(rq_addr),
      .io_requestor_req_bits_tag(rq_tag),
      .io_requestor_req_bits_cmd(rq_cmd),
      .io_requestor_req_bits_typ(rq_typ),
      .io_requestor_req_bits_phys(rq_phys),
      .io_requestor_req_bits_data(rq_data),
      .io_requestor_s1_kill(rq_kill),
      .io_requestor_s1_data(rq_s1_data),
      .io_requestor_s2_nack(rq_nack),
      .io_requestor_resp_valid(rs_valid),
      .io_requestor_resp_bits_tag(rs_tag),
      .io_requestor_resp_bits_data(rs_data),
      .io_requestor_resp_bits_has_data(rs_has),
      .io_requestor_resp_bits_replay(rs_replay),
      .io_requestor_replay_next(rp_next),
      .io_requestor_xcpt(xcpt),
      .io_requestor_invalidate_lr(inv_lr),
      .io_requestor_ordered(ordered),
      .io_mem_req_valid(m_valid),
      .io_mem_req_ready(m_ready),
      .io_mem_req_bits_addr(m_addr),
      .io_mem_req_bits_tag(m_tag),
      .io_mem_req_bits_cmd(m_cmd),
      .io_mem_req_bits_typ(m_typ),
      .io_mem_req_bits_phys(m_phys),
      .io_mem_req_bits_data(m_data),
      .io_mem_s1_kill(m_kill),
      .io_mem_s1_data(m_s1_data),
      .io_mem_s2_nack(m_nack),
      .io_mem_resp_valid(m_rvalid),
      .io_mem_resp_bits_tag(m_rtag),
      .io_mem_resp_bits_data(m_rdata),
      .io_mem_resp_bits_has_data(m_has),
      .io_mem_resp_bits_replay(m_replay),
      .io_mem_replay_next(m_rp_next),
      .io_mem_xcpt(m_xcpt),
      .io_mem_ordered(m_ordered),
      .io_mem_invalidate_lr(m_inv_lr)
   );

`ifdef HELLA_ARB_RR_EN
   logic [2:0]  r_valid, r_ready, r_nack, r_rvalid, r_inv;
   logic [2:0]  r_phys, r_kill;
   logic [95:0] r_addr, r_data, r_s1d;
   logic [26:0] r_tag;
   logic [14:0] r_cmd;
   logic [8:0]  r_typ;
   logic [8:0]  r_rtag;
   logic [31:0] r_rdata, r_maddr, r_mdata, r_ms1d;
   logic        r_has, r_rep, r_rpn, r_ord, r_mvalid;
   logic        r_mready, r_mphys, r_mkill, r_minv;
   logic [3:0]  r_xcpt;
   logic [10:0] r_mtag;
   logic [4:0]  r_mcmd;
   logic [2:0]  r_mtyp;

   hella_cache_arbiter_n #(
      .N(3), .ADDR_W(32), .DATA_W(32), .TAG_W(9)
   ) dut3 (
      .clk(clk), .reset(reset),
      .io_requestor_req_valid(r_valid),
      .io_requestor_req_ready(r_ready),
      .io_requestor_req_bits_addr(r_addr),
      .io_requestor_req_bits_tag(r_tag),
      .io_requestor_req_bits_cmd(r_cmd),
      .io_requestor_req_bits_typ(r_typ),
      .io_requestor_req_bits_phys(r_phys),
      .io_requestor_req_bits_data(r_data),
      .io_requestor_s1_kill(r_kill),
      .io_requestor_s1_data(r_s1d),
      .io_requestor_s2_nack(r_nack),
      .io_requestor_resp_valid(r_rvalid),
      .io_requestor_resp_bits_tag(r_rtag),
      .io_requestor_resp_bits_data(r_rdata),
      .io_requestor_resp_bits_has_data(r_has),
      .io_requestor_resp_bits_replay(r_rep),
      .io_requestor_replay_next(r_rpn),
      .io_requestor_xcpt(r_xcpt),
      .io_requestor_invalidate_lr(r_inv),
      .io_requestor_ordered(r_ord),
      .io_mem_req_valid(r_mvalid),
      .io_mem_req_ready(r_mready),
      .io_mem_req_bits_addr(r_maddr),
      .io_mem_req_bits_tag(r_mtag),
      .io_mem_req_bits_cmd(r_mcmd),
      .io_mem_req_bits_typ(r_mtyp),
      .io_mem_req_bits_phys(r_mphys),
      .io_mem_req_bits_data(r_mdata),
      .io_mem_s1_kill(r_mkill),
      .io_mem_s1_data(r_ms1d),
      .io_mem_s2_nack(1'b0),
      .io_mem_resp_valid(1'b0),
      .io_mem_resp_bits_tag(11'h0),
      .io_mem_resp_bits_data(32'h0),
      .io_mem_resp_bits_has_data(1'b0),
      .io_mem_resp_bits_replay(1'b0),
      .io_mem_replay_next(1'b0),
      .io_mem_xcpt(4'h0),
      .io_mem_ordered(1'b0),
      .io_mem_invalidate_lr(r_minv)
   );
`endif

   task automatic chk(input string tag,
                      input logic [63:0] got,
                      input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Advance to just after the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset     = 1'b1;
      rq_valid  = '0;
      rq_phys   = 2'b10;
      rq_kill   = '0;
      rq_addr   = {32'h2000_0004, 32'h1000_0000};
      rq_data   = {32'hD1D1_D1D1, 32'hD0D0_D0D0};
      rq_s1_data = {32'hBBBB_1111, 32'hAAAA_0000};
      rq_tag    = {9'h122, 9'h011};
      rq_cmd    = {5'h01, 5'h00};
      rq_typ    = {3'd3, 3'd2};
      inv_lr    = '0;
      m_ready   = 1'b1;
      m_nack    = 1'b0;
      m_rvalid  = 1'b0;
      m_rtag    = '0;
      m_rdata   = 32'hCAFE_F00D;
      m_has     = 1'b1;
      m_replay  = 1'b0;
      m_rp_next = 1'b1;
      m_xcpt    = 4'hA;
      m_ordered = 1'b1;
`ifdef HELLA_ARB_RR_EN
      r_valid = '0; r_phys = '0; r_kill = '0; r_inv = '0;
      r_addr = '0; r_data = '0; r_s1d = '0;
      r_tag = {9'h033, 9'h022, 9'h011};
      r_cmd = '0; r_typ = '0; r_mready = 1'b1;
`endif
      tick();
      tick();

      // In reset: stage state cleared, late nack dropped.
      m_nack  = 1'b1;
      rq_kill = 2'b11;
      #1;
      chk("rst_nack", rq_nack, 2'b00);
      chk("rst_kill", m_kill, 1'b0);
      chk("rst_s1data", m_s1_data, 32'h0);

      // First cycle out of reset; both requestors valid.
      tick();
      reset    = 1'b0;
      rq_valid = 2'b11;
      #1;
      chk("post_rst_kill", m_kill, 1'b0);
      chk("post_rst_nack", rq_nack, 2'b00);
      chk("both_ready", rq_ready, 2'b01);
      chk("both_mvalid", m_valid, 1'b1);
      chk("both_tag", m_tag, 10'h022);
      chk("both_addr", m_addr, 32'h1000_0000);
      chk("both_cmd", m_cmd, 5'h00);
      chk("both_phys", m_phys, 1'b0);

      // t: grant req1; s1 holds req0.
      tick();
      m_nack   = 1'b0;
      rq_valid = 2'b10;
      rq_kill  = 2'b10;
      #1;
      chk("t_ready", rq_ready, 2'b10);
      chk("t_tag", m_tag, 10'h245);
      chk("t_data", m_data, 32'hD1D1_D1D1);
      chk("t_typ", m_typ, 3'd3);
      chk("t_kill0", m_kill, 1'b0);
      chk("t_s1data0", m_s1_data, 32'hAAAA_0000);

      // t+1: grant req0; s1 owner is req1.
      tick();
      rq_valid = 2'b01;
      #1;
      chk("t1_ready", rq_ready, 2'b01);
      chk("t1_kill1", m_kill, 1'b1);
      chk("t1_s1data1", m_s1_data, 32'hBBBB_1111);

      // t+2: nack goes to req1; s1 owner is req0.
      tick();
      rq_valid = 2'b00;
      m_nack   = 1'b1;
      #1;
      chk("t2_nack", rq_nack, 2'b10);
      chk("t2_kill", m_kill, 1'b0);
      chk("t2_s1data", m_s1_data, 32'hAAAA_0000);
      chk("t2_mvalid", m_valid, 1'b0);

      // t+3: nack goes to req0; s1 empty.
      tick();
      rq_kill = 2'b11;
      #1;
      chk("t3_nack", rq_nack, 2'b01);
      chk("t3_kill", m_kill, 1'b0);
      chk("t3_s1data", m_s1_data, 32'h0);

      // t+4: s2 empty, nack dropped.
      tick();
      #1;
      chk("t4_nack", rq_nack, 2'b00);

      // Responses routed by index LSB.
      m_nack   = 1'b0;
      m_rvalid = 1'b1;
      m_rtag   = {9'h05A, 1'b1};
      inv_lr   = 2'b10;
      #1;
      chk("resp1_valid", rs_valid, 2'b10);
      chk("resp1_tag", rs_tag, 9'h05A);
      chk("resp_data", rs_data, 32'hCAFE_F00D);
      chk("resp_has", rs_has, 1'b1);
      chk("resp_replay", rs_replay, 1'b0);
      chk("replay_next", rp_next, 1'b1);
      chk("xcpt", xcpt, 4'hA);
      chk("ordered", ordered, 1'b1);
      chk("inv_lr", m_inv_lr, 1'b1);
      m_rtag = {9'h1F0, 1'b0};
      inv_lr = 2'b00;
      #1;
      chk("resp0_valid", rs_valid, 2'b01);
      chk("resp0_tag", rs_tag, 9'h1F0);
      chk("inv_lr0", m_inv_lr, 1'b0);
      m_rvalid = 1'b0;
      #1;
      chk("resp_idle", rs_valid, 2'b00);

      // Cache not ready for 3 cycles: nothing fires.
      m_ready  = 1'b0;
      rq_valid = 2'b01;
      rq_kill  = 2'b11;
      for (int c = 0; c < 3; c++) begin
         tick();
         chk("stall_ready", rq_ready, 2'b00);
         chk("stall_mvalid", m_valid, 1'b1);
         chk("stall_kill", m_kill, 1'b0);
         chk("stall_s1data", m_s1_data, 32'h0);
      end

`ifndef HELLA_ARB_RR_EN
      // Fixed priority keeps favouring req0.
      m_ready  = 1'b1;
      rq_valid = 2'b11;
      tick();
      chk("fp_ready_a", rq_ready, 2'b01);
      tick();
      chk("fp_ready_b", rq_ready, 2'b01);
`endif

      // Reset while s1 is live.
      m_ready  = 1'b1;
      rq_valid = 2'b01;
      rq_kill  = 2'b01;
      tick();
      rq_valid = 2'b00;
      reset    = 1'b1;
      #1;
      chk("mid_s1_live", m_kill, 1'b1);
      tick();
      reset  = 1'b0;
      m_nack = 1'b1;
      #1;
      chk("mid_nack", rq_nack, 2'b00);
      chk("mid_kill", m_kill, 1'b0);
      tick();
      chk("mid_nack2", rq_nack, 2'b00);
      m_nack = 1'b0;

`ifdef HELLA_ARB_RR_EN
      // Round-robin, N=3, all valid: 0,1,2,0.
      r_valid = 3'b111;
      #1;
      chk("rr_g0", r_ready, 3'b001);
      chk("rr_t0", r_mtag, {9'h011, 2'd0});
      tick();
      chk("rr_g1", r_ready, 3'b010);
      chk("rr_t1", r_mtag, {9'h022, 2'd1});
      tick();
      chk("rr_g2", r_ready, 3'b100);
      chk("rr_t2", r_mtag, {9'h033, 2'd2});
      tick();
      chk("rr_g3", r_ready, 3'b001);
      r_valid = 3'b000;
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
